// File: rtl/apple2_fdd_track_cache.sv
// Apple II floppy track cache: writes a dirtied 13-sector track back to the disk image and
// loads the newly selected track through the hps_io sector handshake, stalling the CPU meanwhile.
module apple2_fdd_track_cache #(
  parameter int SECS    = 13,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               track_dirty,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               sd_ack,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic [31:0]        sd_lba,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               dirty
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH_REQ  = 3'd1,
    FLUSH_XFER = 3'd2,
    LOAD_REQ   = 3'd3,
    LOAD_XFER  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_SEC = 4'(SECS - 1);

  function automatic logic [31:0] sector_lba(input logic [TRACK_W-1:0] trk, input logic [3:0] sec);
    return 32'(SECS) * 32'(trk) + 32'(sec);
  endfunction

  state_t             state_r;
  logic [TRACK_W-1:0] cur_r;
  logic               loaded_r;
  logic               mount_pend_r;
  logic               ro_r;
  logic               ack_d_r;

  logic               ack_rise_s;
  logic               ack_fall_s;
  logic               dirty_next_s;
  logic               need_load_s;
  logic               do_flush_s;
  logic               in_flush_s;

  // Handshake edge detection and IDLE-state decisions
  always_comb begin
    ack_rise_s   = sd_ack & ~ack_d_r;
    ack_fall_s   = ~sd_ack & ack_d_r;
    // A CPU write arriving in the same cycle as a track change still forces the flush.
    dirty_next_s = dirty | (track_dirty & ~ro_r & loaded_r);
    need_load_s  = img_present & (mount_pend_r | ~loaded_r | (track != cur_r));
    do_flush_s   = dirty_next_s & ~ro_r & loaded_r & ~mount_pend_r;
    in_flush_s   = (state_r == FLUSH_XFER);
  end

  // Track cache sequencer with registered handshake and status outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_lba       <= 32'd0;
      track_sec    <= 4'd0;
      cpu_wait     <= 1'b0;
      dirty        <= 1'b0;
      loaded_r     <= 1'b0;
      mount_pend_r <= 1'b0;
      ro_r         <= 1'b1;
      cur_r        <= '0;
      ack_d_r      <= 1'b0;
    end else begin
      ack_d_r <= sd_ack;

      // A new image invalidates the buffer contents regardless of what is in flight.
      if (img_mounted) begin
        mount_pend_r <= 1'b1;
        ro_r         <= img_readonly;
        dirty        <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (!img_mounted) begin
            if (!img_present) begin
              mount_pend_r <= 1'b0;
              loaded_r     <= 1'b0;
            end else if (need_load_s) begin
              track_sec <= 4'd0;
              cpu_wait  <= 1'b1;
              if (do_flush_s) begin
                dirty   <= 1'b1;
                state_r <= FLUSH_REQ;
              end else begin
                dirty        <= 1'b0;
                cur_r        <= track;
                mount_pend_r <= 1'b0;
                state_r      <= LOAD_REQ;
              end
            end else begin
              dirty <= dirty_next_s;
            end
          end
        end

        FLUSH_REQ: begin
          sd_lba  <= sector_lba(cur_r, track_sec);
          sd_wr   <= 1'b1;
          state_r <= FLUSH_XFER;
        end

        LOAD_REQ: begin
          sd_lba  <= sector_lba(cur_r, track_sec);
          sd_rd   <= 1'b1;
          state_r <= LOAD_XFER;
        end

        FLUSH_XFER, LOAD_XFER: begin
          if (ack_rise_s) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else if (ack_fall_s) begin
            if (track_sec != LAST_SEC) begin
              track_sec <= track_sec + 4'd1;
              state_r   <= in_flush_s ? FLUSH_REQ : LOAD_REQ;
            end else if (in_flush_s) begin
              // Old track is safely written back; fetch whatever track is selected now.
              dirty     <= 1'b0;
              cur_r     <= track;
              track_sec <= 4'd0;
              state_r   <= LOAD_REQ;
            end else begin
              loaded_r  <= 1'b1;
              track_sec <= 4'd0;
              cpu_wait  <= 1'b0;
              state_r   <= IDLE;
            end
          end
        end

        default: begin
          sd_rd    <= 1'b0;
          sd_wr    <= 1'b0;
          cpu_wait <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
